xor_pipe_unit: RTL and testbench

// - Parametrised, pipelined successor of the 1-bit combinational xor_gate.
// - Combines two WIDTH-bit operands under a 2-bit mode: XOR, XNOR, running-XOR accumulate, or read-and-clear.
// - The accumulate mode keeps a checksum register.
// - Results leave through a STAGES-deep pipeline with valid/ready handshakes on input and output.
// - Sits between a streaming producer and consumer.
// - Used for bitwise compare, masking and checksum generation.
//

---
 rtl/xor_pipe_pkg.sv | 19 +
 rtl/xor_pipe_stage.sv | 41 ++++
 rtl/xor_pipe_unit.sv | 103 ++++++++++
 tb/tb_xor_pipe_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xor_pipe_pkg.sv
// xor_pipe_pkg
//   Shared definitions for the xor_pipe_unit block.
//   mode_e : 2-bit operation select carried on in_mode.
//     MODE_XOR  (00) : r = a ^ b
//     MODE_XNOR (01) : r = ~(a ^ b)
//     MODE_ACC  (10) : r = acc ^ a ^ b, acc <= r
//     MODE_CLR  (11) : r = acc,         acc <= 0
package xor_pipe_pkg;

   localparam int unsigned MODE_W = 2;

   typedef enum logic [MODE_W-1:0] {
      MODE_XOR  = 2'b00,
      MODE_XNOR = 2'b01,
      MODE_ACC  = 2'b10,
      MODE_CLR  = 2'b11
   } mode_e;

endpackage

// File: rtl/xor_pipe_stage.sv
// xor_pipe_stage
//   One register stage of the xor_pipe_unit result pipeline.
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low clear.
//     shift        : stage enable; when low the stage holds.
//     load_valid   : valid bit entering the stage.
//     load_data    : WIDTH-bit result entering the stage.
//     load_parity  : parity of load_data entering the stage.
//     valid/data/parity : registered stage contents.
module xor_pipe_stage
   import xor_pipe_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             shift,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_data,
   input  logic             load_parity,
   output logic             valid,
   output logic [WIDTH-1:0] data,
   output logic             parity
);

   // A bubble only clears the valid bit; the payload keeps its last value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid  <= 1'b0;
         data   <= '0;
         parity <= 1'b0;
      end else if (shift) begin
         valid <= load_valid;
         if (load_valid) begin
            data   <= load_data;
            parity <= load_parity;
         end
      end
   end

endmodule

// File: rtl/xor_pipe_unit.sv
// xor_pipe_unit
//   Pipelined bitwise XOR / XNOR / accumulate / read-and-clear unit with
//   valid/ready handshakes on both sides and a STAGES-deep result pipe.
//   Ports:
//     clk, rst_n  : clock (rising edge), asynchronous active-low reset.
//     in_valid    : operand beat present.
//     in_ready    : unit can accept a beat this cycle.
//     in_a, in_b  : WIDTH-bit operands.
//     in_mode     : 00 XOR, 01 XNOR, 10 ACC, 11 CLR.
//     out_valid   : result beat present.
//     out_ready   : consumer accepts the beat.
//     out_data    : WIDTH-bit result.
//     out_parity  : XOR-reduction of out_data, registered with it.
//     acc_value   : current accumulator register.
module xor_pipe_unit
   import xor_pipe_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_parity,
   output logic [WIDTH-1:0] acc_value
);

   // Index 0 is the stage-0 load; index i+1 is the output of stage i.
   logic [STAGES:0]            pipe_valid;
   logic [STAGES:0][WIDTH-1:0] pipe_data;
   logic [STAGES:0]            pipe_parity;

   logic             advance;
   logic             accept;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_next;

   // The whole pipe moves or the whole pipe freezes; no bubble collapsing.
   assign advance  = !pipe_valid[STAGES] || out_ready;
   assign in_ready = advance;
   assign accept   = in_valid && advance;

   always_comb begin
      result   = '0;
      acc_next = acc;
      case (mode_e'(in_mode))
         MODE_XOR:  result = in_a ^ in_b;
         MODE_XNOR: result = ~(in_a ^ in_b);
         MODE_ACC: begin
            result   = acc ^ in_a ^ in_b;
            acc_next = result;
         end
         MODE_CLR: begin
            result   = acc;
            acc_next = '0;
         end
         default: ;
      endcase
   end

   // accept already implies advance, so a stall also holds the accumulator.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (accept) begin
         acc <= acc_next;
      end
   end

   assign pipe_valid[0]  = accept;
   assign pipe_data[0]   = result;
   assign pipe_parity[0] = ^result;

   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      xor_pipe_stage #(
         .WIDTH (WIDTH)
      ) u_stage (
         .clk         (clk),
         .rst_n       (rst_n),
         .shift       (advance),
         .load_valid  (pipe_valid[i]),
         .load_data   (pipe_data[i]),
         .load_parity (pipe_parity[i]),
         .valid       (pipe_valid[i+1]),
         .data        (pipe_data[i+1]),
         .parity      (pipe_parity[i+1])
      );
   end

   assign out_valid  = pipe_valid[STAGES];
   assign out_data   = pipe_data[STAGES];
   assign out_parity = pipe_parity[STAGES];
   assign acc_value  = acc;

endmodule

// File: tb/tb_xor_pipe_unit.sv
module tb_xor_pipe_unit;
   import xor_pipe_pkg::*;

   localparam int unsigned WIDTH  = 8;
   localparam int unsigned STAGES = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [1:0]       in_mode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_parity;
   logic [WIDTH-1:0] acc_value;

   int checks   = 0;
   int failures = 0;

   logic [WIDTH-1:0] sb[$];
   bit               mon_en = 1'b0;

   xor_pipe_unit #(
      .WIDTH  (WIDTH),
      .STAGES (STAGES)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_mode    (in_mode),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_parity (out_parity),
      .acc_value  (acc_value)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: checks every output transfer against the scoreboard, plus
   // stall behaviour (data stable, in_ready low while output is blocked).
   initial begin
      logic             stalled;
      logic [WIDTH-1:0] held_data;
      logic             held_par;
      logic [WIDTH-1:0] exp;
      stalled = 1'b0;
      held_data = '0;
      held_par = 1'b0;
      forever begin
         @(negedge clk);
         if (mon_en && rst_n) begin
            if (stalled && out_valid) begin
               chk("stall_data_stable", 32'(out_data), 32'(held_data));
               chk("stall_parity_stable", 32'(out_parity), 32'(held_par));
            end
            if (out_valid && !out_ready)
               chk("in_ready_low_when_full", 32'(in_ready), 32'd0);
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  chk("unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
               end else begin
                  exp = sb.pop_front();
                  chk("out_data", 32'(out_data), 32'(exp));
                  chk("out_parity", 32'(out_parity), 32'(^exp));
               end
            end
            stalled   = out_valid && !out_ready;
            held_data = out_data;
            held_par  = out_parity;
         end else begin
            stalled = 1'b0;
         end
      end
   end

   // Offers one beat (inputs change 1 after a rising edge) and returns 1
   // after the edge that accepted it; the expected result is queued.
   task automatic send(input logic [1:0] mode, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp);
      bit done;
      done     = 1'b0;
      in_valid = 1'b1;
      in_mode  = mode;
      in_a     = a;
      in_b     = b;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back(exp);
            @(posedge clk);
            #1;
            done = 1'b1;
         end
      end
      in_valid = 1'b0;
      if (!done) chk("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
      #1;
      chk("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_mode   = 2'b00;
      out_ready = 1'b1;

      // Reset and idle
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_acc", 32'(acc_value), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("idle_in_ready", 32'(in_ready), 32'd1);
      chk("idle_out_valid", 32'(out_valid), 32'd0);
      mon_en = 1'b1;

      // XOR with latency check: visible after the edge following acceptance
      send(MODE_XOR, 8'hF0, 8'h3C, 8'hCC);
      chk("lat_not_early", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      chk("lat_valid_on_time", 32'(out_valid), 32'd1);
      chk("lat_data", 32'(out_data), 32'hCC);
      send(MODE_XNOR, 8'hF0, 8'h3C, 8'h33);
      drain();

      // Accumulate chain then clear
      send(MODE_ACC, 8'h01, 8'h00, 8'h01);
      chk("acc_1", 32'(acc_value), 32'h01);
      send(MODE_ACC, 8'h02, 8'h00, 8'h03);
      send(MODE_ACC, 8'h80, 8'h01, 8'h82);
      chk("acc_3", 32'(acc_value), 32'h82);
      send(MODE_CLR, 8'h5A, 8'hA5, 8'h82);
      chk("acc_clr", 32'(acc_value), 32'h00);
      drain();

      // Backpressure: 6 beats with a 4-cycle output stall in the middle
      fork
         begin
            send(MODE_XOR, 8'h11, 8'h22, 8'h33);
            send(MODE_XOR, 8'h44, 8'h0F, 8'h4B);
            send(MODE_XOR, 8'hA5, 8'h5A, 8'hFF);
            send(MODE_XOR, 8'hFF, 8'h01, 8'hFE);
            send(MODE_XOR, 8'h80, 8'h80, 8'h00);
            send(MODE_XOR, 8'hC3, 8'h3D, 8'hFE);
         end
         begin
            repeat (3) @(posedge clk);
            #1;
            out_ready = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();

      // Stalled input: ACC offered while output is blocked
      out_ready = 1'b0;
      send(MODE_XOR, 8'hAA, 8'h55, 8'hFF);
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_mode  = MODE_ACC;
      in_a     = 8'h05;
      in_b     = 8'h00;
      repeat (3) begin
         @(negedge clk);
         chk("stalled_in_ready", 32'(in_ready), 32'd0);
         chk("stalled_acc_hold", 32'(acc_value), 32'h00);
      end
      @(posedge clk);
      #1;
      chk("stalled_acc_hold_edge", 32'(acc_value), 32'h00);
      out_ready = 1'b1;
      @(negedge clk);
      chk("stalled_ready_back", 32'(in_ready), 32'd1);
      sb.push_back(8'h05);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("stalled_acc_update", 32'(acc_value), 32'h05);
      @(posedge clk);
      #1;
      chk("stalled_acc_once", 32'(acc_value), 32'h05);
      drain();

      // Reset mid-flight with two beats in the pipe
      mon_en = 1'b0;
      send(MODE_ACC, 8'h0F, 8'h00, 8'h0A);
      chk("mid_acc", 32'(acc_value), 32'h0A);
      send(MODE_XOR, 8'h01, 8'h02, 8'h03);
      chk("mid_pipe_full", 32'(out_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_out_data", 32'(out_data), 32'd0);
      chk("mid_rst_acc", 32'(acc_value), 32'd0);
      sb.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("post_rst_no_replay", 32'(out_valid), 32'd0);
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
